// File: rtl/proc_pkg.sv
// Shared processor datapath constants.
package proc_pkg;

    // Default datapath width; storage registers use this for WIDTH.
    localparam int XLEN = 32;

endpackage : proc_pkg

// File: rtl/data_register_if.sv
// Bus bundle for one data_register: load strobe, output enable, data in/out.
interface data_register_if #(
    parameter int WIDTH = proc_pkg::XLEN
);
    logic             i_write;
    logic             i_enable;
    logic [WIDTH-1:0] i_data_in;
    logic [WIDTH-1:0] o_data_out;

    // Driver side: owns the controls and the data to store.
    modport master (
        output i_write,
        output i_enable,
        output i_data_in,
        input  o_data_out
    );

    // Register side.
    modport slave (
        input  i_write,
        input  i_enable,
        input  i_data_in,
        output o_data_out
    );

endinterface : data_register_if

// File: rtl/data_register.sv
// Generic datapath storage register with load strobe and output enable.
// The stored value is only visible while enable is high; otherwise the
// output reads zero. Loads take effect on the rising edge (no write-through).
module data_register
    import proc_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic               clk,
    input  logic               rst,
    data_register_if.slave     bus
);

    logic [WIDTH-1:0] r_q;

    // Zero-width storage makes no sense; refuse to elaborate.
    if (WIDTH < 1) begin : g_bad_width
        $error("data_register: WIDTH must be >= 1");
    end

    // Storage: synchronous active-low reset beats a simultaneous load.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_q <= '0;
        end else if (bus.i_write) begin
            r_q <= bus.i_data_in;
        end
    end

    // Output gate: combinational, follows enable in the same cycle.
    always_comb begin
        bus.o_data_out = bus.i_enable ? r_q : '0;
    end

endmodule : data_register

// File: tb/tb_data_register.sv
// Self-checking bench for data_register at 32 and 16 bits in parallel.
module tb_data_register;
    import proc_pkg::*;

    typedef struct {
        string       tag;
        logic [31:0] v32;
        logic [15:0] v16;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        write;
    logic        enable;
    logic [31:0] din32;
    logic [15:0] din16;

    logic [31:0] m32;
    logic [15:0] m16;

    exp_t exp_q[$];
    int   n_vec;
    int   n_miss;

    data_register_if #(.WIDTH(XLEN)) bus32 ();
    data_register_if #(.WIDTH(16))   bus16 ();

    assign bus32.i_write   = write;
    assign bus32.i_enable  = enable;
    assign bus32.i_data_in = din32;
    assign bus16.i_write   = write;
    assign bus16.i_enable  = enable;
    assign bus16.i_data_in = din16;

    data_register #(.WIDTH(XLEN)) u_dut32 (
        .clk (clk),
        .rst (rst),
        .bus (bus32)
    );

    data_register #(.WIDTH(16)) u_dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic compare_pop();
        exp_t e;
        if (exp_q.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
            return;
        end
        e = exp_q.pop_front();
        chk({e.tag, "_32"}, bus32.o_data_out, e.v32);
        chk({e.tag, "_16"}, {16'd0, bus16.o_data_out}, {16'd0, e.v16});
    endtask

    // One cycle: drive on the falling edge, check the combinational view
    // before the rising edge, then update the model and check after it.
    task automatic apply(input logic r, input logic w, input logic en,
                         input logic [31:0] d32, input logic [15:0] d16,
                         input string tag);
        @(negedge clk);
        rst    = r;
        write  = w;
        enable = en;
        din32  = d32;
        din16  = d16;
        #1;
        if (!$isunknown(m32)) begin
            exp_q.push_back('{ {tag, "_pre"}, en ? m32 : 32'd0, en ? m16 : 16'd0 });
            compare_pop();
        end
        @(posedge clk);
        if (!r) begin
            m32 = '0;
            m16 = '0;
        end else if (w) begin
            m32 = d32;
            m16 = d16;
        end
        #1;
        exp_q.push_back('{ {tag, "_post"}, en ? m32 : 32'd0, en ? m16 : 16'd0 });
        compare_pop();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_vec  = 0;
        n_miss = 0;
        m32    = 'x;
        m16    = 'x;
        rst    = 1'b1;
        write  = 1'b0;
        enable = 1'b0;
        din32  = '0;
        din16  = '0;

        apply(1'b0, 1'b0, 1'b1, 32'd0, 16'd0, "reset");

        for (int i = 0; i < 3; i++)
            apply(1'b1, 1'b1, 1'b0, 32'd25, 16'd30, "wr_hidden");

        for (int i = 0; i < 2; i++)
            apply(1'b1, 1'b0, 1'b0, 32'd40, 16'd40, "hold");
        apply(1'b1, 1'b0, 1'b1, 32'd62, 16'd62, "hold_en");
        chk("hold_const_32", bus32.o_data_out, 32'd25);
        chk("hold_const_16", {16'd0, bus16.o_data_out}, 32'd30);

        apply(1'b1, 1'b0, 1'b0, 32'd62, 16'd62, "en_off");
        chk("en_off_const_32", bus32.o_data_out, 32'd0);
        apply(1'b1, 1'b0, 1'b1, 32'd62, 16'd62, "en_on");
        chk("en_on_const_32", bus32.o_data_out, 32'd25);

        apply(1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 16'hBEEF, "wr_visible");
        chk("wr_vis_const_32", bus32.o_data_out, 32'hDEAD_BEEF);
        chk("wr_vis_const_16", {16'd0, bus16.o_data_out}, 32'h0000_BEEF);

        apply(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 16'hFFFF, "rst_prio");
        chk("rst_prio_const_32", bus32.o_data_out, 32'd0);
        chk("rst_prio_const_16", {16'd0, bus16.o_data_out}, 32'd0);

        for (int i = 0; i < 12; i++) begin
            logic [31:0] d;
            d = $urandom;
            apply(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  d, d[31:16], "rand");
        end

        if (exp_q.size() != 0)
            chk("sb_leftover", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_data_register
